bfm_apb_master_arbiter: RTL and testbench
=========================================

// Module: bfm_apb_master_arbiter
// PURPOSE
//  Shares the single PM-side master port of the BFM APB-to-APB bridge between NUM_M APB requesters.
//  Round-robin arbitration; one transfer in flight at a time.
//  Drives a clean PENABLE_PM rising edge per transfer, since the bridge starts on a PENABLE rise.
//  Returns the bridge's one-cycle PREADY_PM/PSLVERR_PM/PRDATA_PM to the granted requester only.
//  Sits between the testbench BFM masters and the bridge PM port, in the PCLK_PM domain.
// PARAMETERS
//  NUM_M  4  number of requesters, legal 2..8
//  AW     32 address width
//  DW     32 data width
// PORTS
//  PCLK_PM     in   1         clock (all logic in this domain)
//  PRESETN_PM  in   1         reset: asynchronous, active-low
//  PSEL_M      in   NUM_M     per-requester transfer request (APB PSEL)
//  PENABLE_M   in   NUM_M     per-requester access phase; monitored only (see BEHAVIOUR)
//  PWRITE_M    in   NUM_M     per-requester direction
//  PADDR_M     in   NUM_M*AW  requester i at [i*AW +: AW]
//  PWDATA_M    in   NUM_M*DW  requester i at [i*DW +: DW]
//  PRDATA_M    out  NUM_M*DW  read data, per requester
//  PREADY_M    out  NUM_M     completion pulse, per requester
//  PSLVERR_M   out  NUM_M     error, valid with PREADY_M
//  PADDR_PM    out  AW        to bridge
//  PWRITE_PM   out  1         to bridge
//  PENABLE_PM  out  1         to bridge
//  PWDATA_PM   out  DW        to bridge
//  PRDATA_PM   in   DW        from bridge
//  PREADY_PM   in   1         from bridge
//  PSLVERR_PM  in   1         from bridge
//  GRANT       out  NUM_M     one-hot current owner, 0 when idle
//  BUSY        out  1         1 in any state except IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; RR pointer = 0 (M0 highest priority).
//  FSM: IDLE -> SETUP -> ACCESS -> RECOVER -> IDLE.
//  - IDLE
//    - If any PSEL_M, pick first set bit searching from ptr upward, modulo NUM_M.
//    - Register PADDR_PM/PWDATA_PM/PWRITE_PM from the winner; set GRANT; go to SETUP.
//    - Sampled same edge as the decision.
//  - SETUP: PENABLE_PM <= 1; go to ACCESS. PENABLE_PM is guaranteed 0 in the prior cycle.
//  - ACCESS
//    - Hold PENABLE_PM and PADDR/PWDATA/PWRITE_PM stable; wait any number of cycles.
//    - On PREADY_PM=1: PENABLE_PM <= 0; PREADY_M[g] <= 1; PRDATA_M[g] <= PRDATA_PM;
//      PSLVERR_M[g] <= PSLVERR_PM; ptr <= (g+1) mod NUM_M; go to RECOVER.
//  - RECOVER
//    - PREADY_M/PSLVERR_M pulse visible for exactly this one cycle; PENABLE_PM stays 0.
//    - Clear GRANT and PADDR/PWDATA/PWRITE_PM to 0; go to IDLE.
//  Minimum turnaround: 4 PCLK_PM cycles per transfer plus bridge latency.
//  Requesters are gated by PREADY_M, not by PENABLE_M.
//    - Requester i stalls in its access phase until PREADY_M[i].
//    - A PSEL_M drop while granted is ignored: transfer completes, result is discarded.
//  PRDATA_M[i] holds the last value returned to i. PSLVERR_M and PREADY_M are 0 outside RECOVER.
//  PREADY_PM outside ACCESS is ignored; no PREADY_M is generated.
//  Simultaneous requests are resolved solely by ptr; no starvation (max wait NUM_M-1 transfers).
//  Reset mid-transfer: immediate return to reset values. The bridge shares the same reset.
// CONFIGURATION
//  BFM_APBARB_LOCK_EN
//    - Defined: adds input PLOCK_M [NUM_M-1:0]. If PLOCK_M[g]=1 at completion, ptr <= g,
//      so g retains priority for its next request.
//    - Undefined: no port; pure round-robin.
// STRUCTURE
//  Package bfm_apbarb_pkg: state encoding (ARB_IDLE=0, ARB_SETUP=1, ARB_ACCESS=2,
//    ARB_RECOVER=3), max NUM_M constant.
//  Sub-module bfm_rr_arbiter: NUM_M request vector + ptr -> one-hot grant and index.
//    Combinational; the ptr register stays in the parent.
// TESTING
//  - M0 write 0x0100_0010 / 0xDEADBEEF, PREADY_PM after 3 cycles -> PADDR_PM/PWDATA_PM match;
//    PENABLE_PM rises 1 cycle after GRANT; PREADY_M[0] pulses 1 cycle; PSLVERR_M[0]=0.
//  - M0..M3 request together after reset -> grants 0,1,2,3 in order; PENABLE_PM low >= 2 cycles
//    between transfers.
//  - M1 read, PRDATA_PM=0x12345678, PSLVERR_PM=1 -> PRDATA_M[1]=0x12345678; PSLVERR_M[1]=1 one
//    cycle; other PRDATA_M unchanged.
//  - PRESETN_PM low during ACCESS -> all outputs 0 immediately; next grant after release goes to
//    M0 (ptr=0).
//  - PREADY_PM pulse while IDLE -> no PREADY_M asserted; BUSY stays 0.
//  - LOCK_EN: M2 holds PLOCK_M[2]=1, 3 back-to-back transfers, M0 requesting -> M2,M2,M2,M0;
//    macro undefined -> M2,M0,M2,M2.

Source files
------------

// File: rtl/bfm_apbarb_pkg.sv
// Shared types and constants for the PM-side APB master arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package bfm_apbarb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SETUP   = 2'd1,
    ARB_ACCESS  = 2'd2,
    ARB_RECOVER = 2'd3
  } arb_state_t;

  localparam int ARB_MIN_M = 2;
  localparam int ARB_MAX_M = 8;

  // Index width for a requester count; never narrower than one bit.
  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bfm_apb_master_arbiter_if.sv
// Requester-side and bridge-side APB signals of the PM master arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: requesters are held by PREADY_M; the bridge holds by withholding PREADY_PM.
// Optional PLOCK_M bus present only when BFM_APBARB_LOCK_EN is defined.
interface bfm_apb_master_arbiter_if #(
  parameter int NUM_M = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);

  // Requester side
  logic [NUM_M-1:0]    PSEL_M;
  logic [NUM_M-1:0]    PENABLE_M;
  logic [NUM_M-1:0]    PWRITE_M;
  logic [NUM_M*AW-1:0] PADDR_M;
  logic [NUM_M*DW-1:0] PWDATA_M;
  logic [NUM_M*DW-1:0] PRDATA_M;
  logic [NUM_M-1:0]    PREADY_M;
  logic [NUM_M-1:0]    PSLVERR_M;
`ifdef BFM_APBARB_LOCK_EN
  logic [NUM_M-1:0]    PLOCK_M;
`endif

  // Bridge PM side
  logic [AW-1:0]       PADDR_PM;
  logic                PWRITE_PM;
  logic                PENABLE_PM;
  logic [DW-1:0]       PWDATA_PM;
  logic [DW-1:0]       PRDATA_PM;
  logic                PREADY_PM;
  logic                PSLVERR_PM;

  // Status
  logic [NUM_M-1:0]    GRANT;
  logic                BUSY;

  // Arbiter view
  modport slave (
    input  PSEL_M, PENABLE_M, PWRITE_M, PADDR_M, PWDATA_M,
`ifdef BFM_APBARB_LOCK_EN
    input  PLOCK_M,
`endif
    input  PRDATA_PM, PREADY_PM, PSLVERR_PM,
    output PRDATA_M, PREADY_M, PSLVERR_M,
    output PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM,
    output GRANT, BUSY
  );

  // Environment view (requesters + bridge)
  modport master (
    output PSEL_M, PENABLE_M, PWRITE_M, PADDR_M, PWDATA_M,
`ifdef BFM_APBARB_LOCK_EN
    output PLOCK_M,
`endif
    output PRDATA_PM, PREADY_PM, PSLVERR_PM,
    input  PRDATA_M, PREADY_M, PSLVERR_M,
    input  PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM,
    input  GRANT, BUSY
  );

endinterface

// File: rtl/bfm_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo NUM_M.
// Latency: combinational, no state (the pointer register lives in the parent).
// Backpressure: none; gnt_vld low when no request is present.
module bfm_rr_arbiter #(
  parameter int NUM_M = 4,
  parameter int IW    = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [NUM_M-1:0] gnt_oh,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_vld
);

  // Scan NUM_M slots starting at ptr; the first request seen wins.
  always_comb begin
    logic [IW-1:0] slot;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    slot    = '0;
    for (int off = 0; off < NUM_M; off++) begin
      slot = IW'((int'(ptr) + off) % NUM_M);
      if (!gnt_vld && req[slot]) begin
        gnt_vld       = 1'b1;
        gnt_oh[slot]  = 1'b1;
        gnt_idx       = slot;
      end
    end
  end

endmodule

// File: rtl/bfm_apb_master_arbiter.sv
// Shares the bridge PM master port among NUM_M APB requesters, round-robin, one transfer in flight.
// Latency: grant+setup 2 cycles after request, access until PREADY_PM, 1 recover cycle (>= 4 total).
// Backpressure: losing/active requesters stall until their PREADY_M pulse; bridge stalls via PREADY_PM.
// Option BFM_APBARB_LOCK_EN: PLOCK_M[g] at completion keeps the pointer on g.
module bfm_apb_master_arbiter #(
  parameter int NUM_M = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   PCLK_PM,
  input  logic                   PRESETN_PM,
  bfm_apb_master_arbiter_if.slave bus
);

  import bfm_apbarb_pkg::*;

  localparam int IW = arb_idx_w(NUM_M);

  arb_state_t                  state_q, state_d;
  logic [IW-1:0]               ptr_q;
  logic [IW-1:0]               gidx_q;
  logic [NUM_M-1:0]            grant_q;
  logic [NUM_M-1:0]            pready_q;
  logic [NUM_M-1:0]            pslverr_q;
  logic [NUM_M-1:0][DW-1:0]    prdata_q;
  logic [AW-1:0]               paddr_q;
  logic [DW-1:0]               pwdata_q;
  logic                        pwrite_q;
  logic                        penable_q;

  logic [NUM_M-1:0]            win_oh;
  logic [IW-1:0]               win_idx;
  logic                        win_vld;
  logic [AW-1:0]               win_addr;
  logic [DW-1:0]               win_wdata;
  logic                        win_write;
  logic [IW-1:0]               ptr_inc;
  logic [IW-1:0]               ptr_nxt;
  logic                        do_load, do_enable, do_done, do_clear;

  // PENABLE_M is observed only; requesters are paced by PREADY_M.
  logic unused_penable;
  assign unused_penable = ^bus.PENABLE_M;

  bfm_rr_arbiter #(.NUM_M(NUM_M), .IW(IW)) u_rr (
    .req     (bus.PSEL_M),
    .ptr     (ptr_q),
    .gnt_oh  (win_oh),
    .gnt_idx (win_idx),
    .gnt_vld (win_vld)
  );

  // One-hot mux of the winning requester's address phase.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (win_oh[i]) begin
        win_addr  = win_addr  | bus.PADDR_M[i*AW +: AW];
        win_wdata = win_wdata | bus.PWDATA_M[i*DW +: DW];
        win_write = win_write | bus.PWRITE_M[i];
      end
    end
  end

  // Pointer after completion: next requester, or the same one while it holds its lock.
  always_comb begin
    ptr_inc = (gidx_q == IW'(NUM_M - 1)) ? '0 : gidx_q + IW'(1);
`ifdef BFM_APBARB_LOCK_EN
    ptr_nxt = bus.PLOCK_M[gidx_q] ? gidx_q : ptr_inc;
`else
    ptr_nxt = ptr_inc;
`endif
  end

  // FSM state register.
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) state_q <= ARB_IDLE;
    else             state_q <= state_d;
  end

  // FSM next state and per-phase strobes.
  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_enable = 1'b0;
    do_done   = 1'b0;
    do_clear  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_vld) begin
          do_load = 1'b1;
          state_d = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        do_enable = 1'b1;
        state_d   = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        if (bus.PREADY_PM) begin
          do_done = 1'b1;
          state_d = ARB_RECOVER;
        end
      end
      ARB_RECOVER: begin
        do_clear = 1'b1;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Registered datapath: capture winner, raise/drop PENABLE, return response, clear on recover.
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      pready_q  <= '0;
      pslverr_q <= '0;
      prdata_q  <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      if (do_load) begin
        grant_q  <= win_oh;
        gidx_q   <= win_idx;
        paddr_q  <= win_addr;
        pwdata_q <= win_wdata;
        pwrite_q <= win_write;
      end
      if (do_enable) begin
        penable_q <= 1'b1;
      end
      if (do_done) begin
        penable_q           <= 1'b0;
        pready_q[gidx_q]    <= 1'b1;
        pslverr_q[gidx_q]   <= bus.PSLVERR_PM;
        prdata_q[gidx_q]    <= bus.PRDATA_PM;
        ptr_q               <= ptr_nxt;
      end
      if (do_clear) begin
        grant_q   <= '0;
        pready_q  <= '0;
        pslverr_q <= '0;
        paddr_q   <= '0;
        pwdata_q  <= '0;
        pwrite_q  <= 1'b0;
      end
    end
  end

  assign bus.GRANT      = grant_q;
  assign bus.BUSY       = (state_q != ARB_IDLE);
  assign bus.PADDR_PM   = paddr_q;
  assign bus.PWDATA_PM  = pwdata_q;
  assign bus.PWRITE_PM  = pwrite_q;
  assign bus.PENABLE_PM = penable_q;
  assign bus.PREADY_M   = pready_q;
  assign bus.PSLVERR_M  = pslverr_q;
  assign bus.PRDATA_M   = prdata_q;

endmodule

// File: tb/tb_bfm_apb_master_arbiter.sv
// Bench for the PM master arbiter: directed scenarios plus randomized request batches.
// Reference model: per-requester request/count/data arrays, a scalar RR pointer and the pick rule.
`timescale 1ns/1ps
module tb_bfm_apb_master_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bfm_apb_master_arbiter_if #(.NUM_M(NM), .AW(AW), .DW(DW)) bus();

  bfm_apb_master_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW)) dut (
    .PCLK_PM    (clk),
    .PRESETN_PM (rstn),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [NM-1:0] req;
  logic [NM-1:0] lock;
  int            cnt  [NM];
  logic [AW-1:0] a_m  [NM];
  logic [DW-1:0] w_m  [NM];
  logic          wr_m [NM];
  logic [DW-1:0] rd_m [NM];
  int            ptr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NM-1:0] r, input int p);
    for (int k = 0; k < NM; k++) begin
      if (r[(p + k) % NM]) return (p + k) % NM;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [NM-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < NM; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  task automatic drive();
    bus.PSEL_M    = req;
    bus.PENABLE_M = req;
    for (int i = 0; i < NM; i++) begin
      bus.PADDR_M[i*AW +: AW]  = a_m[i];
      bus.PWDATA_M[i*DW +: DW] = w_m[i];
      bus.PWRITE_M[i]          = wr_m[i];
    end
`ifdef BFM_APBARB_LOCK_EN
    bus.PLOCK_M = lock;
`endif
  endtask

  task automatic newdata(input int i);
    a_m[i]  = $urandom;
    w_m[i]  = $urandom;
    wr_m[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    req  = '0;
    lock = '0;
    for (int i = 0; i < NM; i++) begin cnt[i] = 0; rd_m[i] = '0; end
    ptr_m = 0;
    drive();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // One complete transfer as seen by the requesters and the bridge.
  task automatic do_xfer(input int lat, input logic [DW-1:0] rdv, input logic err,
                         input bit early_drop, output int gobs);
    int  g;
    bit  seen;
    g    = pick(req, ptr_m);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.GRANT != '0) seen = 1'b1;
    end
    chk("grant_wait", 64'(seen), 64'(1));
    if (!seen) begin gobs = -1; return; end
    gobs = oh2i(bus.GRANT);
    chk("grant",      64'(bus.GRANT), 64'(1) << g);
    chk("busy_setup", 64'(bus.BUSY), 64'(1));
    chk("pen_setup",  64'(bus.PENABLE_PM), 64'(0));
    chk("paddr",      64'(bus.PADDR_PM), 64'(a_m[g]));
    chk("pwdata",     64'(bus.PWDATA_PM), 64'(w_m[g]));
    chk("pwrite",     64'(bus.PWRITE_PM), 64'(wr_m[g]));
    if (early_drop) begin req[g] = 1'b0; cnt[g] = 0; drive(); end
    @(posedge clk); #1;
    chk("pen_access", 64'(bus.PENABLE_PM), 64'(1));
    repeat (lat) begin
      chk("pready_m_wait", 64'(bus.PREADY_M), 64'(0));
      @(posedge clk); #1;
      chk("pen_hold",   64'(bus.PENABLE_PM), 64'(1));
      chk("paddr_hold", 64'(bus.PADDR_PM), 64'(a_m[g]));
    end
    bus.PREADY_PM  = 1'b1;
    bus.PRDATA_PM  = rdv;
    bus.PSLVERR_PM = err;
    @(posedge clk); #1;
    bus.PREADY_PM  = 1'b0;
    bus.PSLVERR_PM = 1'b0;
    bus.PRDATA_PM  = $urandom;
    rd_m[g] = rdv;
    ptr_m   = lock[g] ? g : (g + 1) % NM;
    chk("pready_m",    64'(bus.PREADY_M), 64'(1) << g);
    chk("pslverr_m",   64'(bus.PSLVERR_M), 64'(err) << g);
    chk("pen_recover", 64'(bus.PENABLE_PM), 64'(0));
    chk("busy_recover", 64'(bus.BUSY), 64'(1));
    for (int i = 0; i < NM; i++) chk("prdata_m", 64'(bus.PRDATA_M[i*DW +: DW]), 64'(rd_m[i]));
    if (!early_drop) begin
      cnt[g]--;
      if (cnt[g] <= 0) req[g] = 1'b0;
      else             newdata(g);
      drive();
    end
    @(posedge clk); #1;
    chk("pready_idle",  64'(bus.PREADY_M), 64'(0));
    chk("pslverr_idle", 64'(bus.PSLVERR_M), 64'(0));
    chk("grant_idle",   64'(bus.GRANT), 64'(0));
    chk("busy_idle",    64'(bus.BUSY), 64'(0));
    chk("paddr_idle",   64'(bus.PADDR_PM), 64'(0));
    chk("pwdata_idle",  64'(bus.PWDATA_PM), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},   64'(bus.GRANT), 64'(0));
    chk({tag, "_busy"},    64'(bus.BUSY), 64'(0));
    chk({tag, "_penable"}, 64'(bus.PENABLE_PM), 64'(0));
    chk({tag, "_paddr"},   64'(bus.PADDR_PM), 64'(0));
    chk({tag, "_pwdata"},  64'(bus.PWDATA_PM), 64'(0));
    chk({tag, "_pwrite"},  64'(bus.PWRITE_PM), 64'(0));
    chk({tag, "_pready"},  64'(bus.PREADY_M), 64'(0));
    chk({tag, "_pslverr"}, 64'(bus.PSLVERR_M), 64'(0));
    for (int i = 0; i < NM; i++) chk({tag, "_prdata"}, 64'(bus.PRDATA_M[i*DW +: DW]), 64'(0));
  endtask

  initial begin
    int gobs;
    int guard;
    int exp_ord [4];
    logic [NM-1:0] mask;

    rstn = 1'b0;
    req  = '0;
    lock = '0;
    ptr_m = 0;
    for (int i = 0; i < NM; i++) begin
      cnt[i] = 0; rd_m[i] = '0; a_m[i] = '0; w_m[i] = '0; wr_m[i] = 1'b0;
    end
    bus.PREADY_PM = 1'b0; bus.PSLVERR_PM = 1'b0; bus.PRDATA_PM = '0;
    drive();
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // M0 write, bridge answers after 3 wait cycles
    a_m[0] = 32'h0100_0010; w_m[0] = 32'hDEAD_BEEF; wr_m[0] = 1'b1;
    req[0] = 1'b1; cnt[0] = 1; drive();
    do_xfer(3, 32'h0, 1'b0, 1'b0, gobs);
    chk("m0_winner", 64'(gobs), 64'(0));

    // All four together after reset: 0,1,2,3
    do_reset();
    for (int i = 0; i < NM; i++) begin newdata(i); cnt[i] = 1; end
    req = '1; drive();
    for (int k = 0; k < NM; k++) begin
      do_xfer(int'($urandom_range(0, 2)), $urandom, 1'b0, 1'b0, gobs);
      chk("rr_order", 64'(gobs), 64'(k));
    end

    // M1 read with error response
    newdata(1); wr_m[1] = 1'b0; req[1] = 1'b1; cnt[1] = 1; drive();
    do_xfer(1, 32'h1234_5678, 1'b1, 1'b0, gobs);
    chk("m1_winner", 64'(gobs), 64'(1));

    // Reset while in ACCESS, then M0 must win against M3
    newdata(1); req[1] = 1'b1; cnt[1] = 1; drive();
    guard = 0;
    while (bus.PENABLE_PM !== 1'b1 && guard < 12) begin @(posedge clk); #1; guard++; end
    chk("reach_access", 64'(bus.PENABLE_PM), 64'(1));
    #2 rstn = 1'b0;
    #1 chk_all_zero("midreset");
    req = '0; for (int i = 0; i < NM; i++) begin cnt[i] = 0; rd_m[i] = '0; end
    ptr_m = 0; drive();
    @(posedge clk); #1 rstn = 1'b1;
    newdata(0); newdata(3); cnt[0] = 1; cnt[3] = 1; req = 4'b1001; drive();
    do_xfer(0, $urandom, 1'b0, 1'b0, gobs);
    chk("post_reset_m0", 64'(gobs), 64'(0));
    do_xfer(2, $urandom, 1'b1, 1'b0, gobs);
    chk("post_reset_m3", 64'(gobs), 64'(3));

    // Stray PREADY_PM while idle
    @(posedge clk); #1;
    bus.PREADY_PM = 1'b1; bus.PSLVERR_PM = 1'b1; bus.PRDATA_PM = $urandom;
    @(posedge clk); #1;
    bus.PREADY_PM = 1'b0; bus.PSLVERR_PM = 1'b0;
    chk("stray_pready", 64'(bus.PREADY_M), 64'(0));
    chk("stray_busy",   64'(bus.BUSY), 64'(0));
    @(posedge clk); #1;
    chk("stray_pready2", 64'(bus.PREADY_M), 64'(0));
    chk("stray_busy2",   64'(bus.BUSY), 64'(0));
    for (int i = 0; i < NM; i++) chk("stray_prdata", 64'(bus.PRDATA_M[i*DW +: DW]), 64'(rd_m[i]));

    // M3 drops PSEL while granted: transfer still completes
    newdata(3); req[3] = 1'b1; cnt[3] = 1; drive();
    do_xfer(2, $urandom, 1'b0, 1'b1, gobs);
    chk("drop_winner", 64'(gobs), 64'(3));

    // Lock scenario: M2 three back-to-back with M0 waiting
    do_reset();
    newdata(1); req[1] = 1'b1; cnt[1] = 1; drive();
    do_xfer(0, $urandom, 1'b0, 1'b0, gobs);
`ifdef BFM_APBARB_LOCK_EN
    lock = 4'b0100;
    exp_ord = '{2, 2, 2, 0};
`else
    exp_ord = '{2, 0, 2, 2};
`endif
    newdata(0); newdata(2); cnt[0] = 1; cnt[2] = 3; req = 4'b0101; drive();
    for (int k = 0; k < 4; k++) begin
      do_xfer(1, $urandom, 1'b0, 1'b0, gobs);
      chk("lock_order", 64'(gobs), 64'(exp_ord[k]));
    end
    lock = '0; drive();

    // Randomized request batches
    for (int b = 0; b < 25; b++) begin
      mask = NM'($urandom_range(1, (1 << NM) - 1));
      for (int i = 0; i < NM; i++) begin
        if (mask[i]) begin cnt[i] = int'($urandom_range(1, 2)); newdata(i); req[i] = 1'b1; end
      end
`ifdef BFM_APBARB_LOCK_EN
      lock = NM'($urandom_range(0, (1 << NM) - 1));
`endif
      drive();
      guard = 0;
      while (req != '0 && guard < 40) begin
        do_xfer(int'($urandom_range(0, 4)), $urandom, 1'($urandom_range(0, 1)), 1'b0, gobs);
        guard++;
      end
      chk("batch_drained", 64'(req), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
